// File: rtl/qracc_psum_accum.sv
// Bit-serial shift-add of per-column ADC planes (MSB first) into signed partial sums; optional saturation via QRACC_PSUM_SAT_EN.
// Latency: psum_valid_o rises 1 cycle after the final plane handshake; one plane per cycle sustained.
// Backpressure: one-deep output register plus one held word; adc_ready_o drops only while a finished word waits (STALL).
module qracc_psum_accum #(
    parameter int numCols    = 32,
    parameter int numAdcBits = 4,
    parameter int numCfgBits = 8,
    parameter int accBits    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [numCfgBits-1:0]         n_input_bits_cfg,
    input  logic                          binary_cfg,
    input  logic [numCols*numAdcBits-1:0] adc_out_i,
    input  logic                          adc_valid_i,
    output logic                          adc_ready_o,
    output logic [numCols*accBits-1:0]    psum_o,
    output logic                          psum_valid_o,
    input  logic                          psum_ready_i,
    output logic                          busy_o,
    output logic                          ovf_o
);

    typedef enum logic [1:0] {IDLE, ACCUM, STALL} state_t;

    state_t                        state_q, state_d;
    logic [numCols*accBits-1:0]    acc, acc_nxt, hold_sum;
    logic [numCfgBits-1:0]         bit_cnt, n_lat, n_src, n_eff;
    logic                          bin_lat, bin_eff, first, last, accept, out_free;
    logic                          wovf, wovf_nxt, hold_ovf, plane_ovf;
    logic                          load_out, from_hold, load_hold, acc_step, acc_clr;
    logic [numAdcBits-1:0]         code [numCols];
    logic [accBits-1:0]            term [numCols];
`ifdef QRACC_PSUM_SAT_EN
    localparam int W = accBits + 1;
    logic [W-1:0]                  shl_w [numCols];
    logic [accBits-1:0]            shl   [numCols];
    logic [W-1:0]                  sum_w [numCols];
`endif

    // Config is taken live only for the first plane; afterwards the latched copy rules the word.
    assign first    = (state_q == IDLE);
    assign bin_eff  = first ? binary_cfg : bin_lat;
    assign n_src    = first ? n_input_bits_cfg : n_lat;
    assign n_eff    = (n_src == '0) ? numCfgBits'(1) : n_src;
    assign last     = (bit_cnt == n_eff - numCfgBits'(1));
    assign out_free = !psum_valid_o || psum_ready_i;
    assign accept   = adc_valid_i && adc_ready_o;
    assign wovf_nxt = (first ? 1'b0 : wovf) | plane_ovf;

    assign adc_ready_o = (state_q != STALL);
    assign busy_o      = (bit_cnt != '0) || (state_q == STALL);

    always_comb begin
        plane_ovf = 1'b0;
        acc_nxt   = '0;
        for (int c = 0; c < numCols; c++) begin
            code[c] = adc_out_i[c*numAdcBits +: numAdcBits];
            if (bin_eff)
                term[c] = {{(accBits-numAdcBits){1'b0}}, code[c]};
            else
                term[c] = {{(accBits-numAdcBits){code[c][numAdcBits-1]}}, code[c]};
            // Binary mode: the MSB plane carries negative weight for two's-complement inputs.
            if (bin_eff && first && (n_eff != numCfgBits'(1)))
                term[c] = -term[c];
`ifdef QRACC_PSUM_SAT_EN
            shl_w[c] = {acc[c*accBits +: accBits], 1'b0};
            if (shl_w[c][W-1] != shl_w[c][W-2]) begin
                shl[c]    = {shl_w[c][W-1], {(accBits-1){~shl_w[c][W-1]}}};
                plane_ovf = 1'b1;
            end else begin
                shl[c] = shl_w[c][accBits-1:0];
            end
            sum_w[c] = {shl[c][accBits-1], shl[c]} + {term[c][accBits-1], term[c]};
            if (sum_w[c][W-1] != sum_w[c][W-2]) begin
                acc_nxt[c*accBits +: accBits] = {sum_w[c][W-1], {(accBits-1){~sum_w[c][W-1]}}};
                plane_ovf = 1'b1;
            end else begin
                acc_nxt[c*accBits +: accBits] = sum_w[c][accBits-1:0];
            end
`else
            acc_nxt[c*accBits +: accBits] = (acc[c*accBits +: accBits] << 1) + term[c];
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        load_out  = 1'b0;
        from_hold = 1'b0;
        load_hold = 1'b0;
        acc_step  = 1'b0;
        acc_clr   = 1'b0;
        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    if (last) begin
                        acc_clr = 1'b1;
                        if (out_free) begin
                            load_out = 1'b1;
                            state_d  = IDLE;
                        end else begin
                            load_hold = 1'b1;
                            state_d   = STALL;
                        end
                    end else begin
                        acc_step = 1'b1;
                        state_d  = ACCUM;
                    end
                end
            end
            STALL: begin
                if (out_free) begin
                    load_out  = 1'b1;
                    from_hold = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc          <= '0;
            bit_cnt      <= '0;
            n_lat        <= '0;
            bin_lat      <= 1'b0;
            wovf         <= 1'b0;
            hold_sum     <= '0;
            hold_ovf     <= 1'b0;
            psum_o       <= '0;
            psum_valid_o <= 1'b0;
            ovf_o        <= 1'b0;
        end else begin
            if (acc_clr) begin
                acc     <= '0;
                bit_cnt <= '0;
                wovf    <= 1'b0;
            end else if (acc_step) begin
                acc     <= acc_nxt;
                bit_cnt <= bit_cnt + numCfgBits'(1);
                wovf    <= wovf_nxt;
                if (first) begin
                    n_lat   <= n_eff;
                    bin_lat <= bin_eff;
                end
            end
            if (load_hold) begin
                hold_sum <= acc_nxt;
                hold_ovf <= wovf_nxt;
            end
            // A drain and a new load on the same edge keep valid high with no bubble.
            if (load_out) begin
                psum_o       <= from_hold ? hold_sum : acc_nxt;
                ovf_o        <= from_hold ? hold_ovf : wovf_nxt;
                psum_valid_o <= 1'b1;
            end else if (psum_ready_i) begin
                psum_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_qracc_psum_accum.sv
// Self-checking bench for qracc_psum_accum: directed scenarios plus randomized words vs an integer reference model.
module tb_qracc_psum_accum;
    localparam int NC = 32, NA = 4, NCFG = 8, ACC = 8;
    localparam int MAXV = (1 << (ACC-1)) - 1;
    localparam int MINV = -(1 << (ACC-1));

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, bcfg, avld, ardy, pvld, prdy, busy, ovf;
    logic [NCFG-1:0]  ncfg;
    logic [NC*NA-1:0] adc;
    logic [NC*ACC-1:0] psum;

    int errors = 0, checks = 0;
    logic [NC*ACC-1:0] got_q[$], exp_q[$];
    bit got_ovf_q[$], exp_ovf_q[$];
    logic [NC*NA-1:0] pl [16];
    bit rand_rdy = 1'b0;

    qracc_psum_accum #(.numCols(NC), .numAdcBits(NA), .numCfgBits(NCFG), .accBits(ACC)) dut (
        .clk(clk), .rst(rst), .n_input_bits_cfg(ncfg), .binary_cfg(bcfg),
        .adc_out_i(adc), .adc_valid_i(avld), .adc_ready_o(ardy),
        .psum_o(psum), .psum_valid_o(pvld), .psum_ready_i(prdy),
        .busy_o(busy), .ovf_o(ovf));

    always @(negedge clk) if (!rst && pvld && prdy) begin
        got_q.push_back(psum);
        got_ovf_q.push_back(ovf);
    end

    always @(posedge clk) if (rand_rdy) begin
        #1 prdy = 1'($urandom_range(0, 1));
    end

    // Present one plane and hold it until accepted, bounded.
    task automatic send_plane(input logic [NC*NA-1:0] d);
        int n = 0;
        adc = d; avld = 1'b1;
        @(negedge clk);
        while (!ardy && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (!ardy) begin errors++; $display("FAIL send_timeout: adc_ready_o=%0b required 1", ardy); end
        @(posedge clk); #1;
        avld = 1'b0;
    endtask

    // Reference: each column is sum of weighted plane terms, MSB first, wrap or clamp at ACC bits.
    task automatic model_word(input int np, input bit bin);
        logic [NC*ACC-1:0] e = '0;
        bit eo = 1'b0;
        logic [NA-1:0] cd;
        int t, s;
        longint ex;
        for (int c = 0; c < NC; c++) begin
            ex = 0; s = 0;
            for (int i = 0; i < np; i++) begin
                cd = pl[i][c*NA +: NA];
                t = int'(cd);
                if (!bin && cd[NA-1]) t = t - (1 << NA);
                if (bin && i == 0 && np > 1) t = -t;
                ex = ex * 2 + t;
                s = s * 2;
                if (s > MAXV) begin s = MAXV; eo = 1'b1; end
                if (s < MINV) begin s = MINV; eo = 1'b1; end
                s = s + t;
                if (s > MAXV) begin s = MAXV; eo = 1'b1; end
                if (s < MINV) begin s = MINV; eo = 1'b1; end
            end
`ifdef QRACC_PSUM_SAT_EN
            e[c*ACC +: ACC] = s[ACC-1:0];
`else
            e[c*ACC +: ACC] = ex[ACC-1:0];
`endif
        end
`ifndef QRACC_PSUM_SAT_EN
        eo = 1'b0;
`endif
        exp_q.push_back(e);
        exp_ovf_q.push_back(eo);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (pvld !== 1'b0) begin errors++; $display("FAIL reset_pvld: got %0b want 0", pvld); end
        checks++; if (psum !== '0) begin errors++; $display("FAIL reset_psum: got %h want 0", psum); end
        checks++; if (ardy !== 1'b1) begin errors++; $display("FAIL reset_ardy: got %0b want 1", ardy); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b want 0", ovf); end
    endtask

    task automatic test_bipolar_n1();
        logic [NC*NA-1:0] d = '0;
        ncfg = 8'd1; bcfg = 1'b0; prdy = 1'b1;
        d[3:0] = 4'hD; d[7:4] = 4'h7;
        send_plane(d);
        checks++; if (pvld !== 1'b1) begin errors++; $display("FAIL bip_pvld: got %0b want 1", pvld); end
        checks++; if (psum[7:0] !== 8'hFD) begin errors++; $display("FAIL bip_col0: got %h want fd", psum[7:0]); end
        checks++; if (psum[15:8] !== 8'h07) begin errors++; $display("FAIL bip_col1: got %h want 07", psum[15:8]); end
        checks++; if (psum[NC*ACC-1:16] !== '0) begin errors++; $display("FAIL bip_rest: got %h want 0", psum[NC*ACC-1:16]); end
        @(posedge clk); #1;
        checks++; if (pvld !== 1'b0) begin errors++; $display("FAIL bip_drain: got %0b want 0", pvld); end
    endtask

    task automatic test_binary_n3();
        logic [NC*NA-1:0] d = '0;
        ncfg = 8'd3; bcfg = 1'b1;
        d[3:0] = 4'd1; send_plane(d);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bin_busy1: got %0b want 1", busy); end
        checks++; if (pvld !== 1'b0) begin errors++; $display("FAIL bin_pvld1: got %0b want 0", pvld); end
        d[3:0] = 4'd2; send_plane(d);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bin_busy2: got %0b want 1", busy); end
        d[3:0] = 4'd3; send_plane(d);
        checks++; if (pvld !== 1'b1) begin errors++; $display("FAIL bin_pvld3: got %0b want 1", pvld); end
        checks++; if (psum[7:0] !== 8'd3) begin errors++; $display("FAIL bin_col0: got %h want 03", psum[7:0]); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bin_busy3: got %0b want 0", busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [NC*NA-1:0] a0, a1, b0, b1;
        got_q.delete(); got_ovf_q.delete(); exp_q.delete(); exp_ovf_q.delete();
        prdy = 1'b0; bcfg = 1'b0; ncfg = 8'd2;
        a0 = {$urandom, $urandom, $urandom, $urandom}; a1 = {$urandom, $urandom, $urandom, $urandom};
        pl[0] = a0; pl[1] = a1; model_word(2, 1'b0);
        b0 = {$urandom, $urandom, $urandom, $urandom}; b1 = {$urandom, $urandom, $urandom, $urandom};
        pl[0] = b0; pl[1] = b1; model_word(2, 1'b0);
        send_plane(a0); send_plane(a1);
        checks++; if (pvld !== 1'b1 || psum !== exp_q[0]) begin errors++; $display("FAIL b2b_w1: vld=%0b psum=%h want %h", pvld, psum, exp_q[0]); end
        send_plane(b0); send_plane(b1);
        checks++; if (ardy !== 1'b0) begin errors++; $display("FAIL b2b_stall_ardy: got %0b want 0", ardy); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_stall_busy: got %0b want 1", busy); end
        @(posedge clk); #1;
        checks++; if (pvld !== 1'b1 || psum !== exp_q[0]) begin errors++; $display("FAIL b2b_hold: vld=%0b psum=%h want %h", pvld, psum, exp_q[0]); end
        checks++; if (ardy !== 1'b0) begin errors++; $display("FAIL b2b_stall_ardy2: got %0b want 0", ardy); end
        prdy = 1'b1;
        repeat (4) @(posedge clk); #1;
        checks++; if (ardy !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: ardy=%0b busy=%0b want 1 0", ardy, busy); end
        checks++; if (got_q.size() != 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", got_q.size()); end
        for (int i = 0; i < 2 && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_mid_reset();
        logic [NC*NA-1:0] d = '0;
        ncfg = 8'd4; bcfg = 1'b0; prdy = 1'b1;
        d[3:0] = 4'd3; send_plane(d); send_plane(d);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mrst_busy_pre: got %0b want 1", busy); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (pvld !== 1'b0 || psum !== '0) begin errors++; $display("FAIL mrst_out: vld=%0b psum=%h want 0 0", pvld, psum); end
        checks++; if (busy !== 1'b0 || ardy !== 1'b1 || ovf !== 1'b0) begin errors++; $display("FAIL mrst_ctl: busy=%0b ardy=%0b ovf=%0b want 0 1 0", busy, ardy, ovf); end
        rst = 1'b0; ncfg = 8'd1; d[3:0] = 4'd5;
        send_plane(d);
        checks++; if (pvld !== 1'b1 || psum[7:0] !== 8'd5) begin errors++; $display("FAIL mrst_next: vld=%0b col0=%h want 1 05", pvld, psum[7:0]); end
        @(posedge clk); #1;
    endtask

    task automatic test_overflow();
        logic [NC*NA-1:0] d = '0;
        logic [7:0] e0, e1;
        logic eo;
`ifdef QRACC_PSUM_SAT_EN
        e0 = 8'h7F; e1 = 8'h80; eo = 1'b1;
`else
        e0 = 8'hF9; e1 = 8'h08; eo = 1'b0;
`endif
        ncfg = 8'd8; bcfg = 1'b0;
        d[3:0] = 4'd7; d[7:4] = 4'h8;
        for (int i = 0; i < 8; i++) send_plane(d);
        checks++; if (pvld !== 1'b1) begin errors++; $display("FAIL ovf_pvld: got %0b want 1", pvld); end
        checks++; if (psum[7:0] !== e0) begin errors++; $display("FAIL ovf_col0: got %h want %h", psum[7:0], e0); end
        checks++; if (psum[15:8] !== e1) begin errors++; $display("FAIL ovf_col1: got %h want %h", psum[15:8], e1); end
        checks++; if (ovf !== eo) begin errors++; $display("FAIL ovf_flag: got %0b want %0b", ovf, eo); end
        @(posedge clk); #1;
    endtask

    task automatic test_cfg_change();
        logic [NC*NA-1:0] d = '0;
        ncfg = 8'd2; bcfg = 1'b0;
        d[3:0] = 4'd3; send_plane(d);
        ncfg = 8'd1; bcfg = 1'b1;
        checks++; if (busy !== 1'b1 || pvld !== 1'b0) begin errors++; $display("FAIL cfg_mid: busy=%0b vld=%0b want 1 0", busy, pvld); end
        d[3:0] = 4'hE; send_plane(d);
        checks++; if (pvld !== 1'b1 || psum[7:0] !== 8'd4) begin errors++; $display("FAIL cfg_word1: vld=%0b col0=%h want 1 04", pvld, psum[7:0]); end
        bcfg = 1'b0; d[3:0] = 4'd3; send_plane(d);
        checks++; if (pvld !== 1'b1 || psum[7:0] !== 8'd3) begin errors++; $display("FAIL cfg_word2: vld=%0b col0=%h want 1 03", pvld, psum[7:0]); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int n, ne;
        bit b;
        got_q.delete(); got_ovf_q.delete(); exp_q.delete(); exp_ovf_q.delete();
        rand_rdy = 1'b1;
        for (int w = 0; w < 40; w++) begin
            n = $urandom_range(0, 6);
            ne = (n == 0) ? 1 : n;
            b = 1'($urandom_range(0, 1));
            for (int i = 0; i < ne; i++) pl[i] = {$urandom, $urandom, $urandom, $urandom};
            model_word(ne, b);
            ncfg = NCFG'(n); bcfg = b;
            for (int i = 0; i < ne; i++) begin
                if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                send_plane(pl[i]);
                ncfg = NCFG'($urandom); bcfg = 1'($urandom_range(0, 1));
            end
        end
        rand_rdy = 1'b0;
        @(posedge clk); #2 prdy = 1'b1;
        repeat (20) @(posedge clk); #1;
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
            checks++; if (got_ovf_q[i] !== exp_ovf_q[i]) begin errors++; $display("FAIL rnd_ovf%0d: got %0b want %0b", i, got_ovf_q[i], exp_ovf_q[i]); end
        end
    endtask

    initial begin
        rst = 1'b1; ncfg = 8'd1; bcfg = 1'b0; adc = '0; avld = 1'b0; prdy = 1'b1;
        test_reset();
        test_bipolar_n1();
        test_binary_n3();
        test_back_to_back();
        test_mid_reset();
        test_overflow();
        test_cfg_change();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
